serial_rx: RTL

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_pkg.sv | 15 +
 rtl/bit_counter.sv | 28 ++
 rtl/serial_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state type and line-level constants for serial_rx and serial_tx
// SERIAL_RX_PARITY_EN adds the PAR state to the receive FSM.
package serial_pkg;

  localparam int   DATA_W_DEF = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, STOP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_t;
`endif

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - data-bit counter with terminal count at DATA_W-1
module bit_counter
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(DATA_W - 1));

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - strobed serial receiver with a one-entry valid/ready output buffer
// SERIAL_RX_PARITY_EN enables an even-parity bit between the data bits and the stop bit.
module serial_rx
  import serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun
);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic              cnt_tc;
  logic              good;

`ifdef SERIAL_RX_PARITY_EN
  logic par_err;
  assign good = (sin == STOP_LEVEL) && !par_err;
`else
  assign good = (sin == STOP_LEVEL);
`endif

  bit_counter #(
    .DATA_W(DATA_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(bit_en && (state == IDLE)),
    .en   (bit_en && (state == DATA)),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (sin != IDLE_LEVEL) begin
              state <= DATA;
            end
          end
          DATA: begin
            shreg <= {sin, shreg[DATA_W-1:1]};
`ifdef SERIAL_RX_PARITY_EN
            if (cnt_tc) state <= PAR;
`else
            if (cnt_tc) state <= STOP;
`endif
          end
`ifdef SERIAL_RX_PARITY_EN
          PAR: begin
            par_err <= (sin != ^shreg);
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
            // Load wins over the clear above when the buffer is freed in this same cycle.
            if (good) begin
              if (!dout_valid || dout_ready) begin
                dout       <= shreg;
                dout_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
